// File: rtl/riscv_bp_pkg.sv
// Shared definitions for the branch predictor: 2-bit direction counter states
// and the index/tag width derivation used by the BTB.
package riscv_bp_pkg;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } ctr_e;

  localparam ctr_e CTR_RST   = WNT;
  localparam ctr_e CTR_ALLOC = WT;

  function automatic int unsigned idx_w(input int unsigned entries);
    int unsigned w;
    w = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < entries) w = i + 1;
    end
    return w;
  endfunction

  function automatic int unsigned tag_w(input int unsigned xlen, input int unsigned entries);
    return xlen - 2 - idx_w(entries);
  endfunction

endpackage

// File: rtl/sat_counter2.sv
// 2-bit saturating direction counter next-state: +1 on taken, -1 on not taken.
module sat_counter2
  import riscv_bp_pkg::*;
(
  input  logic [1:0] ctr_i,
  input  logic       taken_i,
  output logic [1:0] ctr_o
);

  always_comb begin
    ctr_o = ctr_i;
    if (taken_i) begin
      if (ctr_i != ST) ctr_o = ctr_i + 2'd1;
    end else begin
      if (ctr_i != SNT) ctr_o = ctr_i - 2'd1;
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit direction counters: predicts in F, resolves and
// trains in E, and keeps saturating branch/mispredict statistics.
module branch_predictor
  import riscv_bp_pkg::*;
#(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned ENTRIES = 16,
  parameter int unsigned CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [XLEN-1:0]   PCF,
  output logic              PredTakenF,
  output logic [XLEN-1:0]   PredTargetF,
  input  logic              UpdateE,
  input  logic [XLEN-1:0]   PCE,
  input  logic [XLEN-1:0]   PCPlus4E,
  input  logic              TakenE,
  input  logic [XLEN-1:0]   TargetE,
  input  logic              PredTakenE,
  input  logic [XLEN-1:0]   PredTargetE,
  input  logic              Invalidate,
  output logic              MispredictE,
  output logic [XLEN-1:0]   RedirectPCE,
  output logic [CNT_W-1:0]  BranchCount,
  output logic [CNT_W-1:0]  MispredCount
);

  localparam int unsigned IDX_W = idx_w(ENTRIES);
  localparam int unsigned TAG_W = tag_w(XLEN, ENTRIES);

  logic             valid_q [ENTRIES];
  logic [TAG_W-1:0] tag_q   [ENTRIES];
  logic [XLEN-1:0]  tgt_q   [ENTRIES];
  ctr_e             ctr_q   [ENTRIES];

  logic [CNT_W-1:0] bcnt_q, bcnt_d;
  logic [CNT_W-1:0] mcnt_q, mcnt_d;

  logic [IDX_W-1:0] f_idx, e_idx;
  logic [TAG_W-1:0] f_tag, e_tag;
  logic             f_hit, e_hit;
  logic [1:0]       ctr_upd;

  logic unused_pc_lsbs;
  assign unused_pc_lsbs = ^{PCF[1:0], PCE[1:0]};

  // Lookup
  assign f_idx       = PCF[IDX_W+1:2];
  assign f_tag       = PCF[XLEN-1:IDX_W+2];
  assign f_hit       = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
  assign PredTakenF  = f_hit && ctr_q[f_idx][1];
  assign PredTargetF = PredTakenF ? tgt_q[f_idx] : PCF + XLEN'(4);

  // Resolve
  assign MispredictE = UpdateE && ((TakenE != PredTakenE) ||
                                   (TakenE && (TargetE != PredTargetE)));
  assign RedirectPCE = TakenE ? TargetE : PCPlus4E;

  assign e_idx = PCE[IDX_W+1:2];
  assign e_tag = PCE[XLEN-1:IDX_W+2];
  assign e_hit = valid_q[e_idx] && (tag_q[e_idx] == e_tag);

  sat_counter2 u_sat (
    .ctr_i   (ctr_q[e_idx]),
    .taken_i (TakenE),
    .ctr_o   (ctr_upd)
  );

  // Invalidate wins over a same-cycle update; tags/targets are left stale
  // because a cleared valid bit already masks them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        tag_q[i]   <= '0;
        tgt_q[i]   <= '0;
        ctr_q[i]   <= CTR_RST;
      end
    end else if (Invalidate) begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        ctr_q[i]   <= CTR_RST;
      end
    end else if (UpdateE) begin
      if (e_hit) begin
        ctr_q[e_idx] <= ctr_e'(ctr_upd);
        if (TakenE) tgt_q[e_idx] <= TargetE;
      end else if (TakenE) begin
        valid_q[e_idx] <= 1'b1;
        tag_q[e_idx]   <= e_tag;
        tgt_q[e_idx]   <= TargetE;
        ctr_q[e_idx]   <= CTR_ALLOC;
      end
    end
  end

  // Statistics (unaffected by Invalidate)
  always_comb begin
    bcnt_d = bcnt_q;
    mcnt_d = mcnt_q;
    if (UpdateE) begin
      if (bcnt_q != '1) bcnt_d = bcnt_q + CNT_W'(1);
      if (MispredictE && (mcnt_q != '1)) mcnt_d = mcnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bcnt_q <= '0;
      mcnt_q <= '0;
    end else begin
      bcnt_q <= bcnt_d;
      mcnt_q <= mcnt_d;
    end
  end

  assign BranchCount  = bcnt_q;
  assign MispredCount = mcnt_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor: a BTB model checked every cycle plus
// literal expectations along the test-plan sequence.
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] PCF, PCE, PCPlus4E, TargetE, PredTargetE;
  logic        UpdateE, TakenE, PredTakenE, Invalidate;

  logic        PredTakenF, MispredictE;
  logic [31:0] PredTargetF, RedirectPCE;
  logic [15:0] BranchCount, MispredCount;

  logic        PredTakenF2, MispredictE2;
  logic [31:0] PredTargetF2, RedirectPCE2;
  logic [1:0]  BranchCount2, MispredCount2;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  branch_predictor #(.XLEN(32), .ENTRIES(16), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .PCF(PCF), .PredTakenF(PredTakenF), .PredTargetF(PredTargetF),
    .UpdateE(UpdateE), .PCE(PCE), .PCPlus4E(PCPlus4E), .TakenE(TakenE), .TargetE(TargetE),
    .PredTakenE(PredTakenE), .PredTargetE(PredTargetE), .Invalidate(Invalidate),
    .MispredictE(MispredictE), .RedirectPCE(RedirectPCE),
    .BranchCount(BranchCount), .MispredCount(MispredCount)
  );

  branch_predictor #(.XLEN(32), .ENTRIES(16), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .PCF(PCF), .PredTakenF(PredTakenF2), .PredTargetF(PredTargetF2),
    .UpdateE(UpdateE), .PCE(PCE), .PCPlus4E(PCPlus4E), .TakenE(TakenE), .TargetE(TargetE),
    .PredTakenE(PredTakenE), .PredTargetE(PredTargetE), .Invalidate(Invalidate),
    .MispredictE(MispredictE2), .RedirectPCE(RedirectPCE2),
    .BranchCount(BranchCount2), .MispredCount(MispredCount2)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: 16 slots keyed by word address mod 16, tag = PC >> 6,
  // direction strength 0..3 (>=2 means taken).
  bit          m_valid [16];
  int unsigned m_tag   [16];
  int unsigned m_tgt   [16];
  int          m_ctr   [16];
  int          m_bc, m_mc, m_bc2, m_mc2;

  function automatic bit m_misp();
    return UpdateE && ((TakenE != PredTakenE) || (TakenE && (TargetE != PredTargetE)));
  endfunction

  function automatic bit m_hit(input int unsigned pc);
    int unsigned s;
    s = (pc / 4) % 16;
    return m_valid[s] && (m_tag[s] == pc / 64);
  endfunction

  always @(posedge clk or posedge rst) begin
    int unsigned s;
    if (rst) begin
      for (int i = 0; i < 16; i++) begin
        m_valid[i] = 0; m_tag[i] = 0; m_tgt[i] = 0; m_ctr[i] = 1;
      end
      m_bc = 0; m_mc = 0; m_bc2 = 0; m_mc2 = 0;
    end else begin
      if (UpdateE) begin
        if (m_bc < 65535) m_bc++;
        if (m_bc2 < 3) m_bc2++;
        if (m_misp()) begin
          if (m_mc < 65535) m_mc++;
          if (m_mc2 < 3) m_mc2++;
        end
      end
      if (Invalidate) begin
        for (int i = 0; i < 16; i++) begin
          m_valid[i] = 0; m_ctr[i] = 1;
        end
      end else if (UpdateE) begin
        s = (PCE / 4) % 16;
        if (m_hit(PCE)) begin
          m_ctr[s] = TakenE ? ((m_ctr[s] < 3) ? m_ctr[s] + 1 : 3)
                            : ((m_ctr[s] > 0) ? m_ctr[s] - 1 : 0);
          if (TakenE) m_tgt[s] = TargetE;
        end else if (TakenE) begin
          m_valid[s] = 1; m_tag[s] = PCE / 64; m_tgt[s] = TargetE; m_ctr[s] = 2;
        end
      end
    end
  end

  always @(negedge clk) begin
    bit          ptk;
    int unsigned s;
    logic [31:0] ptgt;
    s    = (PCF / 4) % 16;
    ptk  = m_hit(PCF) && (m_ctr[s] >= 2);
    ptgt = ptk ? m_tgt[s] : PCF + 32'd4;
    chk("m_PredTakenF",   PredTakenF,   ptk);
    chk("m_PredTargetF",  PredTargetF,  ptgt);
    chk("m_MispredictE",  MispredictE,  m_misp());
    chk("m_RedirectPCE",  RedirectPCE,  TakenE ? TargetE : PCPlus4E);
    chk("m_BranchCount",  BranchCount,  m_bc);
    chk("m_MispredCount", MispredCount, m_mc);
    chk("m_PredTakenF2",  PredTakenF2,  ptk);
    chk("m_BranchCount2", BranchCount2, m_bc2);
    chk("m_MispredCount2", MispredCount2, m_mc2);
  end

  task automatic drive(input bit upd, input logic [31:0] pce, input bit tk,
                       input logic [31:0] tgt, input bit ptk, input logic [31:0] ptgt,
                       input bit inv, input logic [31:0] pcf);
    UpdateE = upd; PCE = pce; PCPlus4E = pce + 32'd4; TakenE = tk; TargetE = tgt;
    PredTakenE = ptk; PredTargetE = ptgt; Invalidate = inv; PCF = pcf;
  endtask

  task automatic idle(input logic [31:0] pcf);
    drive(0, 32'h0, 0, 32'h0, 0, 32'h4, 0, pcf);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    idle(32'h40);
    @(negedge clk);
    chk("rst_PredTakenF",  PredTakenF,  0);
    chk("rst_PredTargetF", PredTargetF, 32'h44);
    chk("rst_BranchCount", BranchCount, 0);
    chk("rst_MispredCount", MispredCount, 0);
    #1 rst = 1'b0;
    tick();

    // allocate at 0x40; F sees pre-update contents
    drive(1, 32'h40, 1, 32'h100, 0, 32'h44, 0, 32'h40);
    @(negedge clk);
    chk("alloc_Mispredict", MispredictE, 1);
    chk("alloc_Redirect",   RedirectPCE, 32'h100);
    chk("alloc_sameidx_F",  PredTakenF,  0);
    tick();
    idle(32'h40);
    @(negedge clk);
    chk("alloc_PredTakenF",  PredTakenF,  1);
    chk("alloc_PredTargetF", PredTargetF, 32'h100);
    chk("alloc_BranchCount", BranchCount, 1);
    chk("alloc_MispredCount", MispredCount, 1);
    tick();

    // hysteresis: WT -> WNT -> SNT -> WNT -> WT -> ST -> ST -> WT
    drive(1, 32'h40, 0, 32'h0, 1, 32'h100, 0, 32'h40);
    @(negedge clk); chk("hys_WT", PredTakenF, 1); tick();
    drive(1, 32'h40, 0, 32'h0, 0, 32'h44, 0, 32'h40);
    @(negedge clk); chk("hys_WNT", PredTakenF, 0); tick();
    drive(1, 32'h40, 1, 32'h100, 0, 32'h44, 0, 32'h40);
    @(negedge clk); chk("hys_SNT", PredTakenF, 0); tick();
    drive(1, 32'h40, 1, 32'h100, 0, 32'h44, 0, 32'h40);
    @(negedge clk); chk("hys_WNT2", PredTakenF, 0); tick();
    drive(1, 32'h40, 1, 32'h100, 1, 32'h100, 0, 32'h40);
    @(negedge clk);
    chk("hys_WT2", PredTakenF, 1);
    chk("hys_correct_pred", MispredictE, 0);
    tick();
    drive(1, 32'h40, 1, 32'h100, 1, 32'h100, 0, 32'h40);
    @(negedge clk); chk("hys_ST", PredTakenF, 1); tick();
    drive(1, 32'h40, 0, 32'h0, 1, 32'h100, 0, 32'h40);
    @(negedge clk); chk("hys_ST_sat", PredTakenF, 1); tick();
    idle(32'h40);
    @(negedge clk); chk("hys_back_WT", PredTakenF, 1); tick();

    // target mispredict
    drive(1, 32'h40, 1, 32'h200, 1, 32'h100, 0, 32'h40);
    @(negedge clk);
    chk("tgt_Mispredict", MispredictE, 1);
    chk("tgt_Redirect",   RedirectPCE, 32'h200);
    tick();
    idle(32'h40);
    @(negedge clk); chk("tgt_PredTargetF", PredTargetF, 32'h200); tick();

    // aliasing at index 0
    idle(32'h80);
    @(negedge clk);
    chk("alias_PredTakenF",  PredTakenF,  0);
    chk("alias_PredTargetF", PredTargetF, 32'h84);
    tick();
    drive(1, 32'h80, 0, 32'h0, 0, 32'h84, 0, 32'h40);
    @(negedge clk);
    chk("alias_nt_Mispredict", MispredictE, 0);
    chk("alias_nt_Redirect",   RedirectPCE, 32'h84);
    tick();
    drive(0, 32'h0, 1, 32'h300, 0, 32'h4, 0, 32'h40);
    @(negedge clk);
    chk("alias_kept_Taken",  PredTakenF,  1);
    chk("alias_kept_Target", PredTargetF, 32'h200);
    chk("noupd_Mispredict",  MispredictE, 0);
    chk("noupd_Redirect",    RedirectPCE, 32'h300);
    tick();

    // invalidate beats a same-cycle update; stats still count
    drive(1, 32'h40, 1, 32'h500, 1, 32'h200, 1, 32'h40);
    tick();
    idle(32'h40);
    @(negedge clk);
    chk("inv_PredTakenF",   PredTakenF,   0);
    chk("inv_PredTargetF",  PredTargetF,  32'h44);
    chk("inv_BranchCount",  BranchCount,  11);
    chk("inv_MispredCount", MispredCount, 7);
    chk("sat_BranchCount2", BranchCount2, 3);
    chk("sat_MispredCount2", MispredCount2, 3);
    tick();
    drive(1, 32'h40, 1, 32'h600, 0, 32'h44, 0, 32'h40);
    tick();
    idle(32'h40);
    @(negedge clk);
    chk("realloc_Taken",  PredTakenF,  1);
    chk("realloc_Target", PredTargetF, 32'h600);
    tick();

    // async reset mid-cycle with a pending update
    drive(1, 32'h40, 0, 32'h0, 1, 32'h600, 0, 32'h40);
    #1 rst = 1'b1;
    #1;
    chk("arst_BranchCount",  BranchCount,  0);
    chk("arst_MispredCount", MispredCount, 0);
    chk("arst_PredTakenF",   PredTakenF,   0);
    tick();
    rst = 1'b0;
    idle(32'h40);
    @(negedge clk);
    chk("arst_after_Target", PredTargetF, 32'h44);
    chk("arst_after_Count",  BranchCount, 0);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
